csr_regfile: RTL and testbench

- Machine-mode CSR register file for the RV32I pipeline.
- Read port is combinational and sits in ID; its output csr_data feeds the ID/EX CSR segment register.
- Write port is driven from WB and performs the CSRRW/CSRRS/CSRRC read-modify-write internally on the clock edge.
- Owns the free-running 64-bit mcycle and minstret counters, plus their read-only user shadows.

---
 rtl/csr_regfile.sv | 153 +++++++++++++++
 tb/tb_csr_regfile.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file for the RV32I pipeline.
//
// Holds eight plain 32-bit registers, the 64-bit mcycle/minstret counters
// (with read-only 0xC?? shadows) and a constant mhartid.
module csr_regfile #(
  parameter logic [31:0] HART_ID = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_read_addr,
  output logic [31:0] csr_data,
  output logic        csr_read_illegal,
  input  logic        csr_write_en,
  input  logic [11:0] csr_write_addr,
  input  logic [1:0]  csr_write_op,
  input  logic [31:0] csr_write_src,
  output logic        csr_write_illegal,
  input  logic        instr_retire
);

  typedef enum logic [2:0] {
    SelNone, SelStore, SelCycLo, SelCycHi, SelInsLo, SelInsHi, SelHart
  } sel_e;

  // Read-only targets (counter shadows, mhartid) decode only when allow_ro is set,
  // so the shadows alias the machine counters for bypass purposes.
  function automatic sel_e decode_sel(input logic [11:0] a, input logic allow_ro);
    sel_e s;
    s = SelNone;
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340,
      12'h341, 12'h342, 12'h343, 12'h344: s = SelStore;
      12'hB00: s = SelCycLo;
      12'hB80: s = SelCycHi;
      12'hB02: s = SelInsLo;
      12'hB82: s = SelInsHi;
      12'hC00: s = allow_ro ? SelCycLo : SelNone;
      12'hC80: s = allow_ro ? SelCycHi : SelNone;
      12'hC02: s = allow_ro ? SelInsLo : SelNone;
      12'hC82: s = allow_ro ? SelInsHi : SelNone;
      12'hF14: s = allow_ro ? SelHart  : SelNone;
      default: s = SelNone;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] store_idx(input logic [11:0] a);
    logic [2:0] i;
    i = 3'd0;
    case (a)
      12'h304: i = 3'd1;
      12'h305: i = 3'd2;
      12'h340: i = 3'd3;
      12'h341: i = 3'd4;
      12'h342: i = 3'd5;
      12'h343: i = 3'd6;
      12'h344: i = 3'd7;
      default: i = 3'd0;
    endcase
    return i;
  endfunction

  logic [7:0][31:0] store_q, store_d;
  logic [63:0]      mcycle_q, mcycle_d;
  logic [63:0]      minstret_q, minstret_d;

  sel_e        rd_sel, wr_sel;
  logic [2:0]  rd_idx, wr_idx;
  logic [31:0] rd_cur, wr_old, wr_new;
  logic        wr_commit, bypass;
  logic [32:0] cyc_lo_inc, ins_lo_inc;

  assign rd_sel = decode_sel(csr_read_addr, 1'b1);
  assign wr_sel = decode_sel(csr_write_addr, 1'b0);
  assign rd_idx = store_idx(csr_read_addr);
  assign wr_idx = store_idx(csr_write_addr);

  always_comb begin
    rd_cur = '0;
    case (rd_sel)
      SelStore: rd_cur = store_q[rd_idx];
      SelCycLo: rd_cur = mcycle_q[31:0];
      SelCycHi: rd_cur = mcycle_q[63:32];
      SelInsLo: rd_cur = minstret_q[31:0];
      SelInsHi: rd_cur = minstret_q[63:32];
      SelHart:  rd_cur = HART_ID;
      default:  rd_cur = '0;
    endcase
  end

  always_comb begin
    wr_old = '0;
    case (wr_sel)
      SelStore: wr_old = store_q[wr_idx];
      SelCycLo: wr_old = mcycle_q[31:0];
      SelCycHi: wr_old = mcycle_q[63:32];
      SelInsLo: wr_old = minstret_q[31:0];
      SelInsHi: wr_old = minstret_q[63:32];
      default:  wr_old = '0;
    endcase
  end

  always_comb begin
    wr_new = wr_old;
    case (csr_write_op)
      2'b01:   wr_new = csr_write_src;
      2'b10:   wr_new = wr_old | csr_write_src;
      2'b11:   wr_new = wr_old & ~csr_write_src;
      default: wr_new = wr_old;
    endcase
  end

  assign wr_commit = csr_write_en && (wr_sel != SelNone) && (csr_write_op != 2'b00);
  assign bypass    = wr_commit && (rd_sel == wr_sel) && ((rd_sel != SelStore) || (rd_idx == wr_idx));

  assign csr_read_illegal  = (rd_sel == SelNone);
  assign csr_write_illegal = csr_write_en && (wr_sel == SelNone);
  assign csr_data          = (rd_sel == SelNone) ? 32'h0 : (bypass ? wr_new : rd_cur);

  assign cyc_lo_inc = {1'b0, mcycle_q[31:0]} + 33'd1;
  assign ins_lo_inc = {1'b0, minstret_q[31:0]} + {32'h0, instr_retire};

  always_comb begin
    store_d    = store_q;
    mcycle_d   = {mcycle_q[63:32] + {31'h0, cyc_lo_inc[32]}, cyc_lo_inc[31:0]};
    minstret_d = {minstret_q[63:32] + {31'h0, ins_lo_inc[32]}, ins_lo_inc[31:0]};
    if (wr_commit) begin
      case (wr_sel)
        SelStore: store_d[wr_idx] = wr_new;
        // Writing a low half suppresses both its increment and the carry upward.
        SelCycLo: mcycle_d = {mcycle_q[63:32], wr_new};
        // Writing a high half keeps the low increment but drops its carry.
        SelCycHi: mcycle_d[63:32] = wr_new;
        SelInsLo: minstret_d = {minstret_q[63:32], wr_new};
        SelInsHi: minstret_d[63:32] = wr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      store_q    <= store_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: a reference model of the CSR file checked
// every cycle, plus directed vectors with hand-computed values.
module tb_csr_regfile;

  localparam logic [31:0] HART = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_read_addr = '0;
  logic [31:0] csr_data;
  logic        csr_read_illegal;
  logic        csr_write_en = 1'b0;
  logic [11:0] csr_write_addr = '0;
  logic [1:0]  csr_write_op = '0;
  logic [31:0] csr_write_src = '0;
  logic        csr_write_illegal;
  logic        instr_retire = 1'b0;

  always #5 clk = ~clk;

  csr_regfile #(.HART_ID(HART)) dut (
    .clk              (clk),
    .rst              (rst),
    .csr_read_addr    (csr_read_addr),
    .csr_data         (csr_data),
    .csr_read_illegal (csr_read_illegal),
    .csr_write_en     (csr_write_en),
    .csr_write_addr   (csr_write_addr),
    .csr_write_op     (csr_write_op),
    .csr_write_src    (csr_write_src),
    .csr_write_illegal(csr_write_illegal),
    .instr_retire     (instr_retire)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic armed  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ids: 0..7 plain registers, 8/9 cycle lo/hi, 10/11 instret lo/hi, 12 hartid.
  logic [31:0] m_store [8];
  logic [63:0] m_cyc, m_ins;

  function automatic int rd_id(input logic [11:0] a);
    case (a)
      12'h300: return 0;  12'h304: return 1;  12'h305: return 2;  12'h340: return 3;
      12'h341: return 4;  12'h342: return 5;  12'h343: return 6;  12'h344: return 7;
      12'hB00, 12'hC00: return 8;
      12'hB80, 12'hC80: return 9;
      12'hB02, 12'hC02: return 10;
      12'hB82, 12'hC82: return 11;
      12'hF14: return 12;
      default: return -1;
    endcase
  endfunction

  function automatic int wr_id(input logic [11:0] a);
    if (a[11:8] == 4'hC || a == 12'hF14) return -1;
    return rd_id(a);
  endfunction

  function automatic logic [31:0] cur_val(input int id);
    if (id >= 0 && id < 8) return m_store[id];
    case (id)
      8:  return m_cyc[31:0];
      9:  return m_cyc[63:32];
      10: return m_ins[31:0];
      11: return m_ins[63:32];
      12: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rmw(input logic [1:0] op, input logic [31:0] old,
                                      input logic [31:0] src);
    case (op)
      2'b01:   return src;
      2'b10:   return old | src;
      2'b11:   return old & ~src;
      default: return old;
    endcase
  endfunction

  function automatic logic m_commit();
    return csr_write_en && (csr_write_op != 2'b00) && (wr_id(csr_write_addr) >= 0);
  endfunction

  function automatic logic [31:0] m_new();
    return rmw(csr_write_op, cur_val(wr_id(csr_write_addr)), csr_write_src);
  endfunction

  function automatic logic [31:0] exp_data();
    int r;
    r = rd_id(csr_read_addr);
    if (r < 0) return 32'h0;
    if (m_commit() && wr_id(csr_write_addr) == r) return m_new();
    return cur_val(r);
  endfunction

  // 64-bit counter step: increment, then a written half overrides; a written low
  // half keeps the old high half, a written high half keeps the incremented low half.
  function automatic logic [63:0] next_cnt(input logic [63:0] cur, input logic [63:0] inc,
                                           input int lo_id);
    logic [63:0] n;
    int w;
    n = cur + inc;
    if (m_commit()) begin
      w = wr_id(csr_write_addr);
      if (w == lo_id)          n = {cur[63:32], m_new()};
      else if (w == lo_id + 1) n = {m_new(), n[31:0]};
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_store[i] <= '0;
      m_cyc <= '0;
      m_ins <= '0;
      armed <= 1'b1;
    end else begin
      if (m_commit() && wr_id(csr_write_addr) < 8)
        m_store[wr_id(csr_write_addr)] <= m_new();
      m_cyc <= next_cnt(m_cyc, 64'd1, 8);
      m_ins <= next_cnt(m_ins, {63'd0, instr_retire}, 10);
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("model csr_data", csr_data, exp_data());
      chk("model csr_read_illegal", {31'h0, csr_read_illegal},
          {31'h0, rd_id(csr_read_addr) < 0});
      chk("model csr_write_illegal", {31'h0, csr_write_illegal},
          {31'h0, csr_write_en && (wr_id(csr_write_addr) < 0)});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_read_addr = a;
    @(negedge clk);
    chk(name, csr_data, exp);
    step();
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] src);
    csr_write_en   = 1'b1;
    csr_write_addr = a;
    csr_write_op   = op;
    csr_write_src  = src;
    step();
    csr_write_en   = 1'b0;
    csr_write_op   = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two edges, release, then five idle edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rd_chk("mcycle after 5 idle", 12'hB00, 32'd5);
    rd_chk("minstret after reset", 12'hB02, 32'd0);
    rd_chk("mhartid", 12'hF14, HART);
    rd_chk("mstatus reset", 12'h300, 32'h0);
    rd_chk("mtvec reset", 12'h305, 32'h0);
    rd_chk("mip reset", 12'h344, 32'h0);
    rd_chk("mcycleh reset", 12'hB80, 32'h0);

    // Read-modify-write ops on mscratch.
    wr(12'h340, 2'b01, 32'hF0F0_F0F0);
    rd_chk("mscratch write", 12'h340, 32'hF0F0_F0F0);
    wr(12'h340, 2'b10, 32'h0000_000F);
    rd_chk("mscratch set", 12'h340, 32'hF0F0_F0FF);
    wr(12'h340, 2'b11, 32'hF000_0000);
    rd_chk("mscratch clear", 12'h340, 32'h00F0_F0FF);
    wr(12'h340, 2'b00, 32'h1234_5678);
    rd_chk("mscratch op00 no write", 12'h340, 32'h00F0_F0FF);

    // Read-during-write bypass.
    csr_read_addr = 12'h341;
    csr_write_en = 1'b1; csr_write_addr = 12'h341; csr_write_op = 2'b01;
    csr_write_src = 32'h0000_1234;
    @(negedge clk);
    chk("bypass mepc", csr_data, 32'h0000_1234);
    step();
    csr_read_addr = 12'hC00;
    csr_write_addr = 12'hB00; csr_write_src = 32'h10;
    @(negedge clk);
    chk("bypass cycle shadow", csr_data, 32'h10);
    step();
    csr_write_en = 1'b0; csr_write_op = 2'b00;
    rd_chk("mcycle after write 0x10", 12'hB00, 32'h10);
    rd_chk("mcycle counts on", 12'hB00, 32'h11);

    // mcycle carry into mcycleh.
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
    wr(12'hB80, 2'b01, 32'h0000_0001);
    rd_chk("mcycleh written", 12'hB80, 32'h1);
    rd_chk("mcycle low wrapped", 12'hB00, 32'h0);
    rd_chk("mcycleh carried", 12'hB80, 32'h2);

    // minstret full 64-bit wrap.
    wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB82, 2'b01, 32'hFFFF_FFFF);
    instr_retire = 1'b1;
    rd_chk("minstreth all ones", 12'hB82, 32'hFFFF_FFFF);
    instr_retire = 1'b0;
    rd_chk("minstret wrapped lo", 12'hB02, 32'h0);
    rd_chk("minstret wrapped hi", 12'hB82, 32'h0);

    // Write wins over same-cycle increment.
    wr(12'hB00, 2'b01, 32'h100);
    rd_chk("mcycle write wins", 12'hB00, 32'h100);
    rd_chk("mcycle next", 12'hB00, 32'h101);
    instr_retire = 1'b1;
    wr(12'hB02, 2'b01, 32'd7);
    instr_retire = 1'b0;
    rd_chk("minstret write wins", 12'hB02, 32'd7);
    rd_chk("instret shadow", 12'hC02, 32'd7);

    // Illegal accesses.
    csr_read_addr = 12'hC00;
    csr_write_en = 1'b1; csr_write_addr = 12'hC00; csr_write_op = 2'b01;
    csr_write_src = 32'h0000_DEAD;
    @(negedge clk);
    chk("write illegal 0xC00", {31'h0, csr_write_illegal}, 32'h1);
    step();
    csr_write_addr = 12'hF14;
    @(negedge clk);
    chk("write illegal mhartid", {31'h0, csr_write_illegal}, 32'h1);
    step();
    csr_write_en = 1'b0; csr_write_op = 2'b00;
    rd_chk("mhartid unchanged", 12'hF14, HART);
    csr_read_addr = 12'h7C0;
    @(negedge clk);
    chk("read illegal data", csr_data, 32'h0);
    chk("read illegal flag", {31'h0, csr_read_illegal}, 32'h1);
    step();

    // Reset overrides a concurrent set on mtvec.
    wr(12'h305, 2'b01, 32'h0000_0055);
    rd_chk("mtvec before reset", 12'h305, 32'h55);
    rst = 1'b1;
    wr(12'h305, 2'b10, 32'h0000_FF00);
    rst = 1'b0;
    rd_chk("mtvec after reset", 12'h305, 32'h0);
    rd_chk("mcycle restarts", 12'hB00, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
